// File: rtl/div_arb_pkg.sv
// Shared types and constants for the clock-divider rate arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_arb_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] DEFAULT_SEL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LOAD,
        RUN
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// One-hot requester picker: round-robin after ptr, or lowest-index priority.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports: req (request levels), ptr (last granted index), pick (one-hot winner),
//        pick_idx (winner index), pick_vld (any request present).
// Build option: DIV_ARB_PRIORITY_EN selects fixed priority, ignoring ptr.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx,
    output logic            pick_vld
);

    assign pick_vld = |req;
    assign pick     = pick_vld ? (NREQ'(1) << pick_idx) : '0;

`ifdef DIV_ARB_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Walk downwards so the lowest requesting index is written last and wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) pick_idx = IW'(i);
        end
    end
`else
    // Walk offsets from farthest to nearest so the first requester after ptr
    // is written last and wins.
    always_comb begin
        logic [IW-1:0] j;
        j        = '0;
        pick_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) pick_idx = j;
        end
    end
`endif

endmodule

// File: rtl/div_rate_arbiter.sv
// Arbitrates a shared clock divider; pauses it, reloads div_sel, resumes, then grants.
// Latency: grant 1 cycle after sampled req at same rate, SETTLE_CYC+2 on a rate change.
// Backpressure: requesters wait on gnt; holders are revoked after MAX_HOLD if others wait.
//
// Ports: clk, rst_n (async active-low), req/req_sel (per requester level and rate),
//        gnt (one-hot), div_ena/div_sel (to divider), sw_busy (switch in progress).
// Build option: DIV_ARB_PRIORITY_EN -> fixed lowest-index priority, no revocation.
module div_rate_arbiter #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_HOLD   = 1024,
    parameter logic [div_arb_pkg::SEL_W-1:0] DEFAULT_SEL = div_arb_pkg::DEFAULT_SEL
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NREQ-1:0]                    req,
    input  logic [div_arb_pkg::SEL_W*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]                    gnt,
    output logic                               div_ena,
    output logic [div_arb_pkg::SEL_W-1:0]      div_sel,
    output logic                               sw_busy
);

    import div_arb_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t             state;
    logic [NREQ-1:0]        req_q;
    logic [SEL_W*NREQ-1:0]  req_sel_q;
    logic [IW-1:0]          owner;
    logic                   owner_vld;
    logic [SEL_W-1:0]       target;
    logic [CW-1:0]          settle_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [IW-1:0]          rr_ptr;

    logic [NREQ-1:0]        pick;
    logic [IW-1:0]          pick_idx;
    logic                   pick_vld;
    logic [SEL_W-1:0]       pick_sel;
    logic [NREQ-1:0]        owner_oh;
    logic                   revoke;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req      (req_q),
        .ptr      (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_comb begin
        pick_sel = DEFAULT_SEL;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) pick_sel = req_sel_q[i*SEL_W +: SEL_W];
        end
    end

    assign owner_oh = NREQ'(1) << owner;

`ifdef DIV_ARB_PRIORITY_EN
    assign revoke = 1'b0;
`else
    assign revoke = (hold_cnt == HW'(MAX_HOLD)) && |(req_q & ~owner_oh);
`endif

    // Requests are registered first, so every decision below is made on a
    // sample taken one edge earlier; this sets the 1-cycle grant latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            req_sel_q  <= '0;
            gnt        <= '0;
            div_ena    <= 1'b0;
            div_sel    <= DEFAULT_SEL;
            sw_busy    <= 1'b0;
            owner      <= '0;
            owner_vld  <= 1'b0;
            target     <= DEFAULT_SEL;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            rr_ptr     <= IW'(NREQ - 1);
        end else begin
            req_q     <= req;
            req_sel_q <= req_sel;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner     <= pick_idx;
                        owner_vld <= 1'b1;
                        target    <= pick_sel;
                        if (pick_sel == div_sel) begin
                            state    <= RUN;
                            gnt      <= pick;
                            div_ena  <= 1'b1;
                            hold_cnt <= HW'(1);
                            rr_ptr   <= pick_idx;
                        end else begin
                            state      <= GATE;
                            div_ena    <= 1'b0;
                            sw_busy    <= 1'b1;
                            settle_cnt <= '0;
                        end
                    end else if (div_sel == DEFAULT_SEL) begin
                        owner_vld <= 1'b0;
                        div_ena   <= 1'b1;
                    end else begin
                        // Nobody wants the divider: park it back on the default rate.
                        owner_vld  <= 1'b0;
                        target     <= DEFAULT_SEL;
                        state      <= GATE;
                        div_ena    <= 1'b0;
                        sw_busy    <= 1'b1;
                        settle_cnt <= '0;
                    end
                end
                GATE: begin
                    if (settle_cnt == CW'(SETTLE_CYC - 1)) begin
                        state   <= LOAD;
                        div_sel <= target;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    sw_busy <= 1'b0;
                    if (owner_vld && req_q[owner]) begin
                        state    <= RUN;
                        gnt      <= owner_oh;
                        div_ena  <= 1'b1;
                        hold_cnt <= HW'(1);
                        rr_ptr   <= owner;
                    end else begin
                        // Owner gave up during the switch; it never sees a grant.
                        state     <= IDLE;
                        owner_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (!req_q[owner] || revoke) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        owner_vld <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rate_arbiter.sv
module tb_div_rate_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_sel;
    logic [3:0]  gnt;
    logic        div_ena;
    logic [2:0]  div_sel;
    logic        sw_busy;

    int tests = 0;
    int fails = 0;

    div_rate_arbiter #(
        .NREQ       (4),
        .SETTLE_CYC (2),
        .MAX_HOLD   (8),
        .DEFAULT_SEL(3'd7)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_sel (req_sel),
        .gnt     (gnt),
        .div_ena (div_ena),
        .div_sel (div_sel),
        .sw_busy (sw_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] sel;
        logic [3:0]  gnt;
        logic        ena;
        logic [2:0]  dsel;
        logic        busy;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] eg, input logic ee,
                              input logic [2:0] es, input logic eb);
        check(name, {23'd0, gnt, div_ena, div_sel, sw_busy}, {23'd0, eg, ee, es, eb});
    endtask

    int hold_cycles;
    int n;

    initial begin
        // Each row: inputs driven before an edge, outputs expected just after it.
        vecs[0]  = '{4'b0000, 12'h000, 4'b0000, 1'b1, 3'd7, 1'b0};
        vecs[1]  = '{4'b0000, 12'h000, 4'b0000, 1'b1, 3'd7, 1'b0};
        // rate change to 2 for requester 0
        vecs[2]  = '{4'b0001, 12'h002, 4'b0000, 1'b1, 3'd7, 1'b0};
        vecs[3]  = '{4'b0001, 12'h002, 4'b0000, 1'b0, 3'd7, 1'b1};
        vecs[4]  = '{4'b0001, 12'h002, 4'b0000, 1'b0, 3'd7, 1'b1};
        vecs[5]  = '{4'b0001, 12'h002, 4'b0000, 1'b0, 3'd2, 1'b1};
        vecs[6]  = '{4'b0001, 12'h002, 4'b0001, 1'b1, 3'd2, 1'b0};
        vecs[7]  = '{4'b0001, 12'h002, 4'b0001, 1'b1, 3'd2, 1'b0};
        // release, then 1 and 2 request the same rate together
        vecs[8]  = '{4'b0000, 12'h002, 4'b0001, 1'b1, 3'd2, 1'b0};
        vecs[9]  = '{4'b0110, 12'h090, 4'b0000, 1'b1, 3'd2, 1'b0};
        vecs[10] = '{4'b0110, 12'h090, 4'b0010, 1'b1, 3'd2, 1'b0};
        vecs[11] = '{4'b0110, 12'h090, 4'b0010, 1'b1, 3'd2, 1'b0};
        vecs[12] = '{4'b0100, 12'h090, 4'b0010, 1'b1, 3'd2, 1'b0};
        vecs[13] = '{4'b0100, 12'h090, 4'b0000, 1'b1, 3'd2, 1'b0};
        vecs[14] = '{4'b0100, 12'h090, 4'b0100, 1'b1, 3'd2, 1'b0};
        vecs[15] = '{4'b0100, 12'h090, 4'b0100, 1'b1, 3'd2, 1'b0};
        // everyone leaves: divider returns to default rate with no grant
        vecs[16] = '{4'b0000, 12'h090, 4'b0100, 1'b1, 3'd2, 1'b0};
        vecs[17] = '{4'b0000, 12'h000, 4'b0000, 1'b1, 3'd2, 1'b0};
        vecs[18] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd2, 1'b1};
        vecs[19] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd2, 1'b1};
        vecs[20] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd7, 1'b1};
        vecs[21] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd7, 1'b0};
        vecs[22] = '{4'b0000, 12'h000, 4'b0000, 1'b1, 3'd7, 1'b0};
        vecs[23] = '{4'b0000, 12'h000, 4'b0000, 1'b1, 3'd7, 1'b0};
        // requester 3 asks for rate 5 then drops mid-switch: never granted
        vecs[24] = '{4'b1000, 12'hA00, 4'b0000, 1'b1, 3'd7, 1'b0};
        vecs[25] = '{4'b1000, 12'hA00, 4'b0000, 1'b0, 3'd7, 1'b1};
        vecs[26] = '{4'b0000, 12'hA00, 4'b0000, 1'b0, 3'd7, 1'b1};
        vecs[27] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd5, 1'b1};
        vecs[28] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd5, 1'b0};
        vecs[29] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd5, 1'b1};
        vecs[30] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd5, 1'b1};
        vecs[31] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd7, 1'b1};
        vecs[32] = '{4'b0000, 12'h000, 4'b0000, 1'b0, 3'd7, 1'b0};
        vecs[33] = '{4'b0000, 12'h000, 4'b0000, 1'b1, 3'd7, 1'b0};

        rst_n   = 1'b0;
        req     = '0;
        req_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_state", 4'b0000, 1'b0, 3'd7, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req     = vecs[i].req;
            req_sel = vecs[i].sel;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ena, vecs[i].dsel, vecs[i].busy);
            @(negedge clk);
        end

        // Holder 0 at the default rate, requester 3 joins and waits.
        req     = 4'b0001;
        req_sel = 12'hFFF;
        n = 0;
        while (gnt != 4'b0001 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_first_gnt", {28'd0, gnt}, 32'h1);
        @(negedge clk);
        req = 4'b1001;
        hold_cycles = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (gnt == 4'b0001) hold_cycles++;
            else break;
        end
`ifdef DIV_ARB_PRIORITY_EN
        check("hold_no_revoke", hold_cycles, 41);
`else
        check("hold_revoke_cycles", hold_cycles, 8);
        check("revoke_gap", {28'd0, gnt}, 32'h0);
        @(posedge clk);
        #1;
        check("revoke_next_owner", {28'd0, gnt}, 32'h8);
`endif
        @(negedge clk);
        req = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        check_outs("idle_after_hold", 4'b0000, 1'b1, 3'd7, 1'b0);

        // Reset in the middle of a rate switch.
        @(negedge clk);
        req     = 4'b0100;
        req_sel = 12'h040;
        n = 0;
        while (!sw_busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_outs("gate_entered", 4'b0000, 1'b0, 3'd7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("reset_mid_gate", 4'b0000, 1'b0, 3'd7, 1'b0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("after_reset_release", 4'b0000, 1'b1, 3'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
